// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I core front end:
//   - XLEN            : datapath / address width (only 32 is supported)
//   - OP_*            : RV32I major opcodes used by the decode stage
//   - NOP             : canonical NOP encoding (addi x0, x0, 0)
//   - fetch_state_t   : fetch-stage state encoding
//   - word_align()    : clears the two low address bits
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // FETCH : request outstanding, responses go to IF/ID or the skid
    // DROP  : redirect seen while a request is in flight; its data is discarded
    // HOLD  : skid full, no request issued until IF/ID drains
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// One pipeline slot: valid bit, instruction word and its PC.
// Used both as the IF/ID register and as the fetch skid buffer.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load               : capture valid_d/instr_d/pc_d
//   flush              : clear valid (wins over load); instr/pc are kept
//   valid_d/instr_d/pc_d : next contents
//   valid_q/instr_q/pc_q : current contents (reset: 0 / NOP / 0)
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic            valid_d,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    output logic            valid_q,
    output logic [31:0]     instr_q,
    output logic [XLEN-1:0] pc_q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= core_pkg::NOP;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// RV32I instruction fetch plus IF/ID pipeline register.
//   clk, rst_n       : clock, asynchronous active-low reset
//   Imem_Req         : fetch request (address held until Imem_Rvalid)
//   Imem_Addr        : word-aligned fetch address
//   Imem_Rvalid      : response valid (honoured only while Imem_Req=1)
//   Imem_Rdata       : instruction word returned with Imem_Rvalid
//   ID_Stall         : decode cannot accept; IF/ID holds
//   Redirect_Valid   : taken branch/jump from execute; flush and refetch
//   Redirect_PC      : redirect target (low two bits ignored)
//   ID_Valid         : IF/ID holds a valid instruction
//   ID_Instr, ID_PC  : registered instruction and its address
//   ID_Opcode        : ID_Instr[6:0] for the immediate generator
// A response that arrives while decode is stalled is parked in a one-entry
// skid and the request stream pauses (HOLD) until IF/ID drains.
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            Imem_Req,
    output logic [XLEN-1:0] Imem_Addr,
    input  logic            Imem_Rvalid,
    input  logic [31:0]     Imem_Rdata,
    input  logic            ID_Stall,
    input  logic            Redirect_Valid,
    input  logic [XLEN-1:0] Redirect_PC,
    output logic            ID_Valid,
    output logic [31:0]     ID_Instr,
    output logic [6:0]      ID_Opcode,
    output logic [XLEN-1:0] ID_PC
);

    import core_pkg::*;

    fetch_state_t    state;
    logic            req_en;       // keeps Imem_Req low until the first edge after reset
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] drop_target;  // redirect target parked while in DROP
    logic [XLEN-1:0] redir_target;
    logic            rsp;
    logic            accept;

    logic            id_load, id_flush, id_valid_d;
    logic [31:0]     id_instr_d;
    logic [XLEN-1:0] id_pc_d;
    logic            skid_load, skid_flush;
    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    assign redir_target = word_align(Redirect_PC);
    assign Imem_Req     = req_en && (state != HOLD);
    assign Imem_Addr    = fetch_addr;
    assign rsp          = Imem_Req && Imem_Rvalid;
    assign accept       = !ID_Valid || !ID_Stall;
    assign ID_Opcode    = ID_Instr[6:0];

    // Slot control. Redirect outranks a response, which outranks the stall.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        id_load    = 1'b0;
        id_flush   = 1'b0;
        id_valid_d = 1'b1;
        id_instr_d = Imem_Rdata;
        id_pc_d    = fetch_addr;
        skid_load  = 1'b0;
        skid_flush = 1'b0;
        case (state)
            FETCH: begin
                if (Redirect_Valid) begin
                    id_flush = 1'b1;
                end else if (rsp) begin
                    if (accept) id_load   = 1'b1;
                    else        skid_load = 1'b1;
                end else if (accept) begin
                    // decode consumed (or never had) an instruction; nothing new arrived
                    id_flush = 1'b1;
                end
            end
            DROP: begin
                // IF/ID was flushed on entry and stays empty
                id_flush = 1'b1;
            end
            HOLD: begin
                if (Redirect_Valid) begin
                    id_flush   = 1'b1;
                    skid_flush = 1'b1;
                end else if (accept) begin
                    id_load    = 1'b1;
                    id_valid_d = skid_valid;
                    id_instr_d = skid_instr;
                    id_pc_d    = skid_pc;
                    skid_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            req_en      <= 1'b0;
            fetch_addr  <= RESET_PC;
            drop_target <= RESET_PC;
        end else begin
            req_en <= 1'b1;
            case (state)
                FETCH: begin
                    if (Redirect_Valid) begin
                        if (rsp) begin
                            // the in-flight request just completed, so retarget now
                            fetch_addr <= redir_target;
                        end else begin
                            // address must stay stable until the response lands
                            drop_target <= redir_target;
                            state       <= DROP;
                        end
                    end else if (rsp) begin
                        fetch_addr <= fetch_addr + XLEN'(4);
                        if (!accept) state <= HOLD;
                    end
                end
                DROP: begin
                    if (rsp) begin
                        fetch_addr <= Redirect_Valid ? redir_target : drop_target;
                        state      <= FETCH;
                    end else if (Redirect_Valid) begin
                        drop_target <= redir_target;
                    end
                end
                HOLD: begin
                    if (Redirect_Valid) begin
                        fetch_addr <= redir_target;
                        state      <= FETCH;
                    end else if (accept) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (id_load),
        .flush   (id_flush),
        .valid_d (id_valid_d),
        .instr_d (id_instr_d),
        .pc_d    (id_pc_d),
        .valid_q (ID_Valid),
        .instr_q (ID_Instr),
        .pc_q    (ID_PC)
    );

    if_id_reg #(.XLEN(XLEN)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .flush   (skid_flush),
        .valid_d (1'b1),
        .instr_d (Imem_Rdata),
        .pc_d    (fetch_addr),
        .valid_q (skid_valid),
        .instr_q (skid_instr),
        .pc_q    (skid_pc)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed scenarios followed by a randomized run. A memory responder with a
// programmable wait count returns mem_word(addr). A program-order scoreboard
// expects decode to consume RESET_PC, +4, +8 ... with each redirect restarting
// the stream at the aligned target and squashing whatever sat in IF/ID.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Rvalid;
    logic [31:0] Imem_Rdata;
    logic        ID_Stall;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        ID_Valid;
    logic [31:0] ID_Instr;
    logic [6:0]  ID_Opcode;
    logic [31:0] ID_PC;

    int          checks   = 0;
    int          errors   = 0;
    int          mem_wait = 0;
    int          consumed = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    if_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Imem_Req       (Imem_Req),
        .Imem_Addr      (Imem_Addr),
        .Imem_Rvalid    (Imem_Rvalid),
        .Imem_Rdata     (Imem_Rdata),
        .ID_Stall       (ID_Stall),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_PC    (Redirect_PC),
        .ID_Valid       (ID_Valid),
        .ID_Instr       (ID_Instr),
        .ID_Opcode      (ID_Opcode),
        .ID_PC          (ID_PC)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[26:2], 7'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        Redirect_Valid = 1'b0;
        ID_Stall       = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (ID_Valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, ok, 1);
    endtask

    // Memory responder: Rvalid rises once the current request has been
    // pending for mem_wait cycles. Also checks address stability/alignment.
    initial begin
        bit          hs;
        bit          was_req;
        int          cnt;
        logic [31:0] pend_addr;
        Imem_Rvalid = 1'b0;
        Imem_Rdata  = '0;
        cnt         = 0;
        was_req     = 1'b0;
        pend_addr   = '0;
        forever begin
            @(negedge clk);
            hs = (rst_n === 1'b1) && (Imem_Req === 1'b1) && (Imem_Rvalid === 1'b1);
            @(posedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                Imem_Rvalid = 1'b0;
                cnt         = 0;
                was_req     = 1'b0;
            end else begin
                if (hs) cnt = 0;
                if (Imem_Req === 1'b1) begin
                    check("addr_aligned", Imem_Addr[1:0], 0);
                    if (was_req && !hs) check("addr_stable", Imem_Addr, pend_addr);
                    if (cnt >= mem_wait) begin
                        Imem_Rvalid = 1'b1;
                        Imem_Rdata  = mem_word(Imem_Addr);
                    end else begin
                        Imem_Rvalid = 1'b0;
                    end
                    cnt++;
                end else begin
                    Imem_Rvalid = 1'b0;
                end
                was_req   = (Imem_Req === 1'b1);
                pend_addr = Imem_Addr;
            end
        end
    end

    // Program-order scoreboard on instructions decode actually takes.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                exp_pc = RESET_PC;
            end else if (Redirect_Valid === 1'b1) begin
                exp_pc = Redirect_PC & 32'hFFFF_FFFC;
            end else if (ID_Valid === 1'b1 && ID_Stall === 1'b0) begin
                check("sb_pc", ID_PC, exp_pc);
                check("sb_instr", ID_Instr, mem_word(exp_pc));
                check("sb_opcode", ID_Opcode, 7'h13);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_a;
        int          base;

        rst_n          = 1'b0;
        ID_Stall       = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_PC    = '0;
        mem_wait       = 0;

        // 1: reset values, then 0-wait streaming
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ID_Valid, 0);
        check("rst_instr", ID_Instr, NOP_W);
        check("rst_pc", ID_PC, 0);
        check("rst_addr", Imem_Addr, RESET_PC);
        check("rst_req", Imem_Req, 0);
        rst_n = 1'b1;
        step();
        check("t1_req", Imem_Req, 1);
        check("t1_addr0", Imem_Addr, RESET_PC);
        check("t1_valid0", ID_Valid, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("t1_addr_%0d", i), Imem_Addr, 4 * i);
            check($sformatf("t1_pc_%0d", i), ID_PC, 4 * (i - 1));
            check($sformatf("t1_valid_%0d", i), ID_Valid, 1);
            check($sformatf("t1_opc_%0d", i), ID_Opcode, 7'h13);
        end

        // 2: 3-wait memory, one instruction every 4 cycles
        mem_wait = 3;
        exp_a    = 32'h14;
        for (int r = 0; r < 2; r++) begin
            for (int j = 1; j <= 3; j++) begin
                step();
                check($sformatf("t2_req_%0d_%0d", r, j), Imem_Req, 1);
                check($sformatf("t2_addr_%0d_%0d", r, j), Imem_Addr, exp_a);
                check($sformatf("t2_idle_%0d_%0d", r, j), ID_Valid, 0);
            end
            step();
            check($sformatf("t2_valid_%0d", r), ID_Valid, 1);
            check($sformatf("t2_pc_%0d", r), ID_PC, exp_a);
            check($sformatf("t2_next_%0d", r), Imem_Addr, exp_a + 32'd4);
            exp_a = exp_a + 32'd4;
        end

        // 3: stall while the 0x10 response lands -> HOLD, then drain in order
        mem_wait = 0;
        apply_reset();
        repeat (4) step();
        check("t3_pc_pre", ID_PC, 32'h0C);
        check("t3_addr_pre", Imem_Addr, 32'h10);
        ID_Stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("t3_req_%0d", i), Imem_Req, 0);
            check($sformatf("t3_pc_%0d", i), ID_PC, 32'h0C);
            check($sformatf("t3_valid_%0d", i), ID_Valid, 1);
        end
        ID_Stall = 1'b0;
        step();
        check("t3_pc_10", ID_PC, 32'h10);
        check("t3_instr_10", ID_Instr, mem_word(32'h10));
        step();
        check("t3_pc_14", ID_PC, 32'h14);
        check("t3_valid_14", ID_Valid, 1);

        // 4: redirect while the 2-wait fetch of 0x08 is outstanding
        mem_wait = 2;
        apply_reset();
        repeat (6) step();
        check("t4_addr_8", Imem_Addr, 32'h08);
        check("t4_pc_4", ID_PC, 32'h04);
        step();
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h200;
        step();
        Redirect_Valid = 1'b0;
        check("t4_drop_addr", Imem_Addr, 32'h08);
        check("t4_drop_req", Imem_Req, 1);
        check("t4_drop_valid", ID_Valid, 0);
        step();
        check("t4_tgt_addr", Imem_Addr, 32'h200);
        check("t4_tgt_valid", ID_Valid, 0);
        wait_valid("t4_first", 10);
        check("t4_pc_200", ID_PC, 32'h200);
        wait_valid("t4_second", 10);
        check("t4_pc_204", ID_PC, 32'h204);

        // 5: redirect while stalled in HOLD; skid discarded, target aligned
        mem_wait = 0;
        apply_reset();
        repeat (2) step();
        ID_Stall = 1'b1;
        step();
        check("t5_hold_req", Imem_Req, 0);
        check("t5_hold_pc", ID_PC, 32'h04);
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h103;
        step();
        Redirect_Valid = 1'b0;
        ID_Stall       = 1'b0;
        check("t5_flush_valid", ID_Valid, 0);
        check("t5_addr", Imem_Addr, 32'h100);
        check("t5_req", Imem_Req, 1);
        step();
        check("t5_pc_100", ID_PC, 32'h100);
        check("t5_valid_100", ID_Valid, 1);
        step();
        check("t5_pc_104", ID_PC, 32'h104);

        // 6: reset during a wait at 0x40, restart, then address wrap
        apply_reset();
        repeat (16) step();
        check("t6_addr_40", Imem_Addr, 32'h40);
        mem_wait = 3;
        step();
        check("t6_wait_addr", Imem_Addr, 32'h40);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", ID_Valid, 0);
        check("t6_rst_instr", ID_Instr, NOP_W);
        check("t6_rst_pc", ID_PC, 0);
        check("t6_rst_addr", Imem_Addr, RESET_PC);
        mem_wait = 0;
        step();
        rst_n = 1'b1;
        step();
        check("t6_restart_addr", Imem_Addr, RESET_PC);
        check("t6_restart_req", Imem_Req, 1);
        step();
        check("t6_restart_pc", ID_PC, RESET_PC);
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'hFFFF_FFFC;
        step();
        Redirect_Valid = 1'b0;
        check("t6_top_addr", Imem_Addr, 32'hFFFF_FFFC);
        check("t6_top_valid", ID_Valid, 0);
        step();
        check("t6_top_pc", ID_PC, 32'hFFFF_FFFC);
        check("t6_wrap_addr", Imem_Addr, 32'h0);
        step();
        check("t6_wrap_pc", ID_PC, 32'h0);
        check("t6_wrap_valid", ID_Valid, 1);

        // Randomized stalls, wait states and redirects against the scoreboard
        apply_reset();
        base = consumed;
        for (int n = 0; n < 2000; n++) begin
            step();
            ID_Stall = ($urandom_range(0, 3) == 0);
            mem_wait = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) begin
                Redirect_Valid = 1'b1;
                Redirect_PC    = $urandom;
            end else begin
                Redirect_Valid = 1'b0;
            end
        end
        Redirect_Valid = 1'b0;
        ID_Stall       = 1'b0;
        step();
        check("rand_progress", ((consumed - base) >= 200), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
